// File: rtl/dsp_engine_seq_xfade.sv
// Per-sample sequencer: input gain, pipeline tick/wait, crossfaded pipeline select, output gain.
// Optional PIPE_WATCHDOG_EN: bounds the WAIT state and adds the sticky wdog_trip_o flag.
module dsp_engine_seq_xfade #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned N_PIPELINES = 2,
  parameter int unsigned GAIN_SHIFT  = 5,
  parameter int unsigned XFADE_LEN   = 64,
`ifdef PIPE_WATCHDOG_EN
  parameter int unsigned WDOG_CYCLES = 4096,
`endif
  parameter int unsigned CTR_WIDTH   = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [DATA_WIDTH-1:0]             in_sample_i,
  input  logic                              sample_ready_i,
  output logic                              ready_o,
  output logic [DATA_WIDTH-1:0]             out_sample_o,
  output logic                              out_valid_o,
  output logic [DATA_WIDTH-1:0]             pipe_in_sample_o,
  output logic                              pipe_tick_o,
  input  logic [N_PIPELINES-1:0]            pipe_ready_i,
  input  logic [N_PIPELINES*DATA_WIDTH-1:0] pipe_out_i,
  input  logic [DATA_WIDTH-1:0]             gain_data_i,
  input  logic                              set_input_gain_i,
  input  logic                              set_output_gain_i,
  input  logic                              swap_req_i,
  input  logic [$clog2(N_PIPELINES)-1:0]    swap_target_i,
  output logic                              swapping_o,
  output logic [$clog2(N_PIPELINES)-1:0]    current_pipeline_o,
  output logic                              overrun_o,
`ifdef PIPE_WATCHDOG_EN
  output logic                              wdog_trip_o,
`endif
  output logic [CTR_WIDTH-1:0]              sample_count_o
);

  localparam int unsigned SEL_W   = $clog2(N_PIPELINES);
  localparam int unsigned XF_BITS = $clog2(XFADE_LEN);
  localparam int unsigned K_W     = XF_BITS + 1;
  localparam int unsigned PROD_W  = 2 * DATA_WIDTH;
  localparam int unsigned MIX_W   = DATA_WIDTH + K_W + 2;
`ifdef PIPE_WATCHDOG_EN
  localparam int unsigned WD_W    = $clog2(WDOG_CYCLES + 1);
`endif

  localparam logic signed [PROD_W-1:0] SAT_MAX = (PROD_W'(1) <<< (DATA_WIDTH - 1)) - PROD_W'(1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = -(PROD_W'(1) <<< (DATA_WIDTH - 1));
  localparam logic [DATA_WIDTH-1:0]    UNITY   = DATA_WIDTH'(1) << GAIN_SHIFT;

  typedef enum logic [2:0] {
    S_IDLE, S_GAIN, S_TICK, S_SETTLE, S_WAIT, S_MIX, S_OUT
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [DATA_WIDTH-1:0]  sample_q, sample_d;
  logic [DATA_WIDTH-1:0]  pipe_in_q, pipe_in_d;
  logic                   pipe_tick_q, pipe_tick_d;
  logic [DATA_WIDTH-1:0]  out_sample_q, out_sample_d;
  logic                   out_valid_q, out_valid_d;
  logic [CTR_WIDTH-1:0]   count_q, count_d;
  logic                   overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]  in_gain_q, in_gain_d;
  logic [DATA_WIDTH-1:0]  out_gain_q, out_gain_d;
  logic                   swapping_q, swapping_d;
  logic [SEL_W-1:0]       target_q, target_d;
  logic [SEL_W-1:0]       cur_q, cur_d;
  logic [K_W-1:0]         k_q, k_d;
`ifdef PIPE_WATCHDOG_EN
  logic [WD_W-1:0]        wdog_cnt_q, wdog_cnt_d;
  logic                   wdog_trip_q, wdog_trip_d;
  logic                   wdog_hit_q, wdog_hit_d;
`endif

  logic [DATA_WIDTH-1:0]  lane_c [N_PIPELINES];
  logic [DATA_WIDTH-1:0]  a_c, b_c, m_c;
  logic [K_W-1:0]         weight_a_c;
  logic signed [MIX_W-1:0] mix_sum_c;
  logic                   swap_ok_c;

  // Scaled product with arithmetic shift; full 2*DATA_WIDTH product avoids overflow.
  function automatic logic signed [PROD_W-1:0] gain_mul(input logic [DATA_WIDTH-1:0] x,
                                                         input logic [DATA_WIDTH-1:0] g);
    logic signed [PROD_W-1:0] xe;
    logic signed [PROD_W-1:0] ge;
    xe = PROD_W'($signed(x));
    ge = PROD_W'($signed(g));
    return (xe * ge) >>> GAIN_SHIFT;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX)      return DATA_WIDTH'(SAT_MAX);
    else if (v < SAT_MIN) return DATA_WIDTH'(SAT_MIN);
    else                  return DATA_WIDTH'(v);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(N_PIPELINES); i++) begin
      lane_c[i] = pipe_out_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Linear crossfade: weights (XFADE_LEN-k) and k always sum to a power of two.
  always_comb begin
    a_c        = lane_c[cur_q];
    b_c        = lane_c[target_q];
    weight_a_c = K_W'(XFADE_LEN) - k_q;
    mix_sum_c  = MIX_W'($signed(a_c)) * MIX_W'($signed({1'b0, weight_a_c}))
               + MIX_W'($signed(b_c)) * MIX_W'($signed({1'b0, k_q}));
    m_c        = swapping_q ? DATA_WIDTH'(mix_sum_c >>> XF_BITS) : a_c;
  end

  assign swap_ok_c = swap_req_i && !swapping_q && (swap_target_i != cur_q)
                  && (int'(swap_target_i) < int'(N_PIPELINES));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    sample_d     = sample_q;
    pipe_in_d    = pipe_in_q;
    pipe_tick_d  = 1'b0;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    count_d      = count_q;
    overrun_d    = overrun_q;
    in_gain_d    = in_gain_q;
    out_gain_d   = out_gain_q;
    swapping_d   = swapping_q;
    target_d     = target_q;
    cur_d        = cur_q;
    k_d          = k_q;
`ifdef PIPE_WATCHDOG_EN
    wdog_cnt_d   = wdog_cnt_q;
    wdog_trip_d  = wdog_trip_q;
    wdog_hit_d   = wdog_hit_q;
`endif

    if (set_input_gain_i)  in_gain_d  = gain_data_i;
    if (set_output_gain_i) out_gain_d = gain_data_i;
    if (swap_ok_c) begin
      swapping_d = 1'b1;
      target_d   = swap_target_i;
    end
    if (sample_ready_i && (state_q != S_IDLE)) overrun_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (sample_ready_i) begin
          sample_d = in_sample_i;
          ready_d  = 1'b0;
          count_d  = count_q + CTR_WIDTH'(1);
`ifdef PIPE_WATCHDOG_EN
          wdog_hit_d = 1'b0;
`endif
          state_d  = S_GAIN;
        end
      end
      S_GAIN: begin
        pipe_in_d   = sat(gain_mul(sample_q, in_gain_q));
        pipe_tick_d = 1'b1;
        state_d     = S_TICK;
      end
      S_TICK: state_d = S_SETTLE;
      S_SETTLE: begin
`ifdef PIPE_WATCHDOG_EN
        wdog_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (&pipe_ready_i) begin
          state_d = S_MIX;
`ifdef PIPE_WATCHDOG_EN
        end else if (wdog_cnt_q == WD_W'(WDOG_CYCLES - 1)) begin
          // Timed out: re-emit the held output sample without reapplying gain.
          out_valid_d = 1'b1;
          wdog_trip_d = 1'b1;
          wdog_hit_d  = 1'b1;
          state_d     = S_OUT;
        end else begin
          wdog_cnt_d = wdog_cnt_q + WD_W'(1);
`endif
        end
      end
      S_MIX: begin
        out_sample_d = sat(gain_mul(m_c, out_gain_q));
        out_valid_d  = 1'b1;
        state_d      = S_OUT;
      end
      S_OUT: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
`ifdef PIPE_WATCHDOG_EN
        if (swapping_q && !wdog_hit_q) begin
`else
        if (swapping_q) begin
`endif
          if (k_q == K_W'(XFADE_LEN - 1)) begin
            cur_d      = target_q;
            swapping_d = 1'b0;
            k_d        = '0;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q      <= 1'b1;
      sample_q     <= '0;
      pipe_in_q    <= '0;
      pipe_tick_q  <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      in_gain_q    <= UNITY;
      out_gain_q   <= UNITY;
      swapping_q   <= 1'b0;
      target_q     <= '0;
      cur_q        <= '0;
      k_q          <= '0;
`ifdef PIPE_WATCHDOG_EN
      wdog_cnt_q   <= '0;
      wdog_trip_q  <= 1'b0;
      wdog_hit_q   <= 1'b0;
`endif
    end else begin
      ready_q      <= ready_d;
      sample_q     <= sample_d;
      pipe_in_q    <= pipe_in_d;
      pipe_tick_q  <= pipe_tick_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      in_gain_q    <= in_gain_d;
      out_gain_q   <= out_gain_d;
      swapping_q   <= swapping_d;
      target_q     <= target_d;
      cur_q        <= cur_d;
      k_q          <= k_d;
`ifdef PIPE_WATCHDOG_EN
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_trip_q  <= wdog_trip_d;
      wdog_hit_q   <= wdog_hit_d;
`endif
    end
  end

  assign ready_o            = ready_q;
  assign out_sample_o       = out_sample_q;
  assign out_valid_o        = out_valid_q;
  assign pipe_in_sample_o   = pipe_in_q;
  assign pipe_tick_o        = pipe_tick_q;
  assign swapping_o         = swapping_q;
  assign current_pipeline_o = cur_q;
  assign overrun_o          = overrun_q;
  assign sample_count_o     = count_q;
`ifdef PIPE_WATCHDOG_EN
  assign wdog_trip_o        = wdog_trip_q;
`endif

endmodule
